if_stage: RTL and testbench
===========================

# if_stage

Instruction Fetch stage of the RISC-Vibe 5-stage RV32I pipeline. It owns the PC, issues in-order requests to instruction memory over a valid/ready request channel, and collects in-order responses in a 2-entry fetch queue. It presents the oldest completed fetch as `if_id_out` to the IF/ID register that feeds `id_stage`. It absorbs pipeline stalls and branch/jump redirects without losing or duplicating instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `clk`  in  1  pipeline clock.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `stall`  in  1  hazard unit: hold the current `if_id_out`, no pop.
- `flush`  in  1  hazard unit: force `if_id_out.valid=0` this cycle (bubble).
- `redirect_valid`  in  1  EX-stage taken branch/jump.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (treated as 0).
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_rsp_valid`  in  1  response valid; responses arrive in request order, no backpressure.
- `imem_rsp_data`  in  32  fetched instruction.
- `if_id_out`  out  `if_id_reg_t`  {pc, pc_plus_4, instruction, valid}.

## Operation
- State:
  - `pc_q`: next address to request.
  - Fetch queue: 2 entries, each {pc, instr, filled}; head/tail pointers plus `count` 0..2.
  - `drop_cnt` 0..2: stale responses to discard.
- Issue: `imem_req_valid = !redirect_valid && drop_cnt==0 && (count<2 || pop)`, where `pop = head.filled && !stall && !flush`. `imem_req_addr = pc_q`.
- Accept (`valid && ready`): allocate a tail entry {pc_q, filled=0}; `pc_q += 4`.
- Response with `drop_cnt>0`: discarded, `drop_cnt--`. Otherwise: fills the oldest unfilled entry with `imem_rsp_data`.
- Output: `if_id_out` is the head entry, combinational. `valid = head.filled && count>0 && !flush`, `pc_plus_4 = pc+4`. When there is no valid head, `instruction = 32'h0000_0013` (NOP).
- Pop: on `pop`, the head is freed.
- Redirect, same cycle:
  - Queue cleared (`count=0`).
  - `pc_q = {redirect_pc[31:2],2'b00}`.
  - `drop_cnt` = unfilled entries, minus 1 if a response arrives this cycle.
  - `if_id_out.valid=0`.
- Flush without redirect: bubble only, no pop, queue retained.
- Stall: head and `pc_q` are held. Responses keep filling, and requests continue while `count<2`.
- Request stability: `imem_req_addr` is stable while `valid && !ready`. `redirect_valid` withdraws a pending unaccepted request, so the address changes on the next issue.
- An unknown/zero instruction word is passed through; decode handles it.

## Timing
- Reset (async, `rst_n=0`):
  - `pc_q=RESET_PC`, `count=0`, `drop_cnt=0`.
  - `imem_req_valid=0`, `if_id_out.valid=0`, `if_id_out.instruction=NOP`, `if_id_out.pc=0`.
- First request: asserted in the first cycle after reset release.
- Latency: with 1-cycle memory, request accepted at cycle N, response at N+1, `if_id_out.valid` at N+2. Throughput is 1 instr/cycle sustained.
- Redirect penalty: discard of up to 2 stale responses, then issue of the target. Target valid at ≥ (stale-drain + 2) cycles.
- Simultaneous events:
  - Redirect + response: the response is stale (dropped), never enqueued.
  - Redirect + stall: redirect wins.
  - Pop + allocate when `count==2`: both occur and `count` stays 2.
  - Response + pop in the same cycle: both occur.
- Reset mid-operation: all state cleared asynchronously. In-flight memory responses after release are the environment's responsibility (memory is reset together).

## Structure
- `riscvibe_pkg` holds:
  - `if_id_reg_t` (existing).
  - `NOP_INSTR` (32'h0000_0013).
  - `RESET_PC_DEFAULT`.
  - `fetch_entry_t` {pc, instr, filled}.
- One sub-module: `fetch_queue`, a 2-entry in-order alloc/fill/pop queue with clear. `if_stage` holds the PC, the issue logic, and `drop_cnt`.

## Test plan
- Reset release, `RESET_PC=0`, 1-cycle memory always ready -> requests 0x0, 0x4, 0x8 on consecutive cycles. `if_id_out` pc 0x0 valid 2 cycles after the first accept, then one instruction per cycle.
- `stall` held 3 cycles while streaming -> `if_id_out` frozen at the same pc/instr, at most 2 outstanding entries, no drop or duplicate after release.
- `imem_req_ready=0` for 4 cycles -> `imem_req_addr` constant (0x8), `pc_q` not advanced.
- Two requests in flight (0x10, 0x14), redirect to 0x103 -> both responses discarded (`drop_cnt` 2→0), next request 0x100, first valid output pc 0x100.
- Redirect in the same cycle as a response -> response dropped, `drop_cnt` correct, no stale pc ever valid.
- `flush` alone for 1 cycle -> `if_id_out.valid=0` that cycle. The same head is presented valid the next cycle.

Source files
------------

// File: rtl/riscvibe_pkg.sv
// Shared types and constants for the RISC-Vibe pipeline front end.
// The IF/ID register layout is consumed as-is by id_stage.
package riscvibe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] instruction;
    logic        valid;
  } if_id_reg_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order fetch queue: entries are allocated at request accept,
// filled by in-order responses (oldest unfilled first) and popped at the head.
module fetch_queue
  import riscvibe_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         alloc_i,
  input  logic [31:0]  alloc_pc_i,
  input  logic         fill_i,
  input  logic [31:0]  fill_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o,
  output logic [1:0]   unfilled_o
);

  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic [1:0] count_q, count_d;

  fetch_entry_t [1:0] ent_w;
  logic [1:0]         slot_unf;
  logic               fill_idx;
  logic               fill_en;

  always_comb begin
    slot_unf = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (((count_q == 2'd2) || ((count_q == 2'd1) && (head_q == 1'(i)))) && !ent_w[i].filled) begin
        slot_unf[i] = 1'b1;
      end
    end
  end

  // Responses return in request order, so the oldest unfilled slot is the target.
  assign fill_idx   = slot_unf[head_q] ? head_q : ~head_q;
  assign fill_en    = fill_i && !clear_i && (slot_unf != 2'b00);
  assign unfilled_o = {1'b0, slot_unf[0]} + {1'b0, slot_unf[1]};

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    fetch_entry_t ent_q, ent_d;

    always_comb begin
      ent_d = ent_q;
      if (fill_en && (fill_idx == 1'(gi))) begin
        ent_d.instr  = fill_data_i;
        ent_d.filled = 1'b1;
      end
      if (alloc_i && !clear_i && (tail_q == 1'(gi))) begin
        ent_d.pc     = alloc_pc_i;
        ent_d.instr  = NOP_INSTR;
        ent_d.filled = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ent_q <= '{pc: 32'h0, instr: NOP_INSTR, filled: 1'b0};
      end else begin
        ent_q <= ent_d;
      end
    end

    assign ent_w[gi] = ent_q;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (alloc_i) tail_d = ~tail_q;
      if (pop_i)   head_d = ~head_q;
      case ({alloc_i, pop_i})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = ent_w[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, issues in-order imem requests, discards
// responses made stale by a redirect and presents the oldest fetch to IF/ID.
module if_stage
  import riscvibe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output if_id_reg_t  if_id_out
);

  logic [31:0]  pc_q, pc_d;
  logic [1:0]   drop_q, drop_d;
  logic [2:0]   drop_sum;

  fetch_entry_t head;
  logic [1:0]   count;
  logic [1:0]   unfilled;
  logic         head_live;
  logic         pop;
  logic         accept;
  logic         fill;
  logic [31:0]  out_pc;

  assign head_live = (count != 2'd0) && head.filled;
  assign pop       = head_live && !stall && !flush && !redirect_valid;
  assign accept    = imem_req_valid && imem_req_ready;
  assign fill      = imem_rsp_valid && (drop_q == 2'd0) && !redirect_valid;

  assign imem_req_valid = rst_n && !redirect_valid && (drop_q == 2'd0) && ((count != 2'd2) || pop);
  assign imem_req_addr  = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
    end else if (accept) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Every in-flight request not yet answered becomes stale on a redirect;
  // a response arriving in the redirect cycle itself is one of them.
  assign drop_sum = {1'b0, drop_q} + {1'b0, unfilled};

  always_comb begin
    drop_d = drop_q;
    if (redirect_valid) begin
      if (imem_rsp_valid && (drop_sum != 3'd0)) begin
        drop_d = 2'(drop_sum - 3'd1);
      end else begin
        drop_d = 2'(drop_sum);
      end
    end else if (imem_rsp_valid && (drop_q != 2'd0)) begin
      drop_d = drop_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= word_align(RESET_PC);
      drop_q <= 2'd0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_queue u_fetch_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (redirect_valid),
    .alloc_i     (accept),
    .alloc_pc_i  (pc_q),
    .fill_i      (fill),
    .fill_data_i (imem_rsp_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .unfilled_o  (unfilled)
  );

  assign out_pc = (count != 2'd0) ? head.pc : 32'h0;

  always_comb begin
    if_id_out.pc          = out_pc;
    if_id_out.pc_plus_4   = out_pc + 32'd4;
    if_id_out.instruction = head_live ? head.instr : NOP_INSTR;
    if_id_out.valid       = head_live && !flush && !redirect_valid;
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: in-order memory model with variable latency, a
// program-order retirement model, directed scenarios and a random soak.
module tb_if_stage;
  import riscvibe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  if_id_reg_t  if_id_out;

  always #5 clk = ~clk;

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_id_out      (if_id_out)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  int          last_due;
  int          mem_lat;
  bit          mem_lat_rand;

  logic [31:0] exp_pc;
  logic [31:0] req_exp;
  bit          prev_pending;
  logic [31:0] prev_addr;
  int          cyc;
  int          pops;
  int          idle;
  int          max_idle;
  int          rsp_count;
  bit          verbose;

  logic [31:0] acc_addr_q[$];
  int          acc_cyc_q[$];
  bit          obs_valid[64];
  logic [31:0] obs_pc[64];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    imem_req_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    #1;
    chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
    chk("reset_out_valid", 32'(if_id_out.valid), 32'd0);
    chk("reset_out_instr", if_id_out.instruction, NOP_INSTR);
    chk("reset_out_pc", if_id_out.pc, 32'h0);
    memq.delete();
    acc_addr_q.delete();
    acc_cyc_q.delete();
    for (int i = 0; i < 64; i++) begin
      obs_valid[i] = 1'b0;
      obs_pc[i] = 32'h0;
    end
    last_due = 0; exp_pc = 32'h0; req_exp = 32'h0; prev_pending = 1'b0;
    prev_addr = 32'h0; cyc = 0; idle = 0; rsp_count = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs after the edge, check at the falling edge.
  task automatic step(input bit rdy, input bit st, input bit fl, input bit rv, input logic [31:0] rpc);
    int lat;
    int due;
    @(posedge clk);
    #1;
    cyc++;
    imem_req_ready = rdy; stall = st; flush = fl;
    redirect_valid = rv; redirect_pc = rpc;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem_word(memq[0].addr);
      void'(memq.pop_front());
      rsp_count++;
    end
    #4;
    if (cyc < 64) begin
      obs_valid[cyc] = if_id_out.valid;
      obs_pc[cyc] = if_id_out.pc;
    end
    if (rv || fl) chk("bubble_valid", 32'(if_id_out.valid), 32'd0);
    if (rv) chk("redirect_req_withdrawn", 32'(imem_req_valid), 32'd0);
    if (if_id_out.valid) begin
      chk("out_pc", if_id_out.pc, exp_pc);
      chk("out_instr", if_id_out.instruction, mem_word(exp_pc));
      chk("out_pc_plus_4", if_id_out.pc_plus_4, exp_pc + 32'd4);
    end
    if (prev_pending) begin
      if (!rv) chk("req_valid_held", 32'(imem_req_valid), 32'd1);
      if (imem_req_valid) chk("req_addr_stable", imem_req_addr, prev_addr);
    end
    if (imem_req_valid && rdy) begin
      chk("req_addr", imem_req_addr, req_exp);
      lat = mem_lat_rand ? int'($urandom_range(1, 3)) : mem_lat;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{addr: imem_req_addr, due: due});
      acc_addr_q.push_back(imem_req_addr);
      acc_cyc_q.push_back(cyc);
      req_exp = req_exp + 32'd4;
      chk("outstanding_le_2", 32'(memq.size() <= 2), 32'd1);
      if (verbose) $display("req  cyc=%0d addr=%h", cyc, imem_req_addr);
    end
    prev_pending = imem_req_valid && !rdy;
    prev_addr = imem_req_addr;
    if (if_id_out.valid && !st) begin
      if (verbose) $display("ret  cyc=%0d pc=%h instr=%h", cyc, if_id_out.pc, if_id_out.instruction);
      exp_pc = exp_pc + 32'd4;
      pops++;
      idle = 0;
    end else begin
      idle++;
      if (idle > max_idle) max_idle = idle;
    end
    if (rv) begin
      exp_pc = {rpc[31:2], 2'b00};
      req_exp = {rpc[31:2], 2'b00};
      prev_pending = 1'b0;
      if (verbose) $display("redir cyc=%0d target=%h", cyc, rpc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_pc;
    bit          found;
    int          rsp0;
    int          nacc;
    int          nsteps;
    pops = 0; max_idle = 0; mem_lat = 1; mem_lat_rand = 1'b0; verbose = 1'b1;

    // Latency and throughput from reset with a 1-cycle memory.
    do_reset();
    repeat (6) step(1, 0, 0, 0, 32'h0);
    chk("A_accept_count", 32'(acc_addr_q.size()), 32'd6);
    if (acc_addr_q.size() >= 3) begin
      chk("A_acc0_addr", acc_addr_q[0], 32'h0);
      chk("A_acc1_addr", acc_addr_q[1], 32'h4);
      chk("A_acc2_addr", acc_addr_q[2], 32'h8);
      chk("A_acc0_cyc", 32'(acc_cyc_q[0]), 32'd1);
      chk("A_acc2_cyc", 32'(acc_cyc_q[2]), 32'd3);
    end
    chk("A_no_valid_c2", 32'(obs_valid[2]), 32'd0);
    chk("A_valid_c3", 32'(obs_valid[3]), 32'd1);
    chk("A_pc_c3", obs_pc[3], 32'h0);
    chk("A_valid_c4", 32'(obs_valid[4]), 32'd1);
    chk("A_pc_c4", obs_pc[4], 32'h4);
    chk("A_pc_c5", obs_pc[5], 32'h8);

    // Request held while memory is not ready, then stall and flush.
    do_reset();
    repeat (2) step(1, 0, 0, 0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 32'h0);
      chk("B_req_valid_hold", 32'(imem_req_valid), 32'd1);
      chk("B_req_addr_hold", imem_req_addr, 32'h8);
    end
    repeat (5) step(1, 0, 0, 0, 32'h0);
    hold_pc = exp_pc;
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 0, 32'h0);
      chk("B_stall_valid", 32'(if_id_out.valid), 32'd1);
      chk("B_stall_pc", if_id_out.pc, hold_pc);
    end
    repeat (4) step(1, 0, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    hold_pc = exp_pc;
    step(1, 0, 1, 0, 32'h0);
    chk("B_flush_bubble", 32'(if_id_out.valid), 32'd0);
    step(1, 0, 0, 0, 32'h0);
    chk("B_after_flush_valid", 32'(if_id_out.valid), 32'd1);
    chk("B_after_flush_pc", if_id_out.pc, hold_pc);
    repeat (4) step(1, 0, 0, 0, 32'h0);

    // Redirect with two unanswered requests (0x10, 0x14) in flight.
    do_reset();
    mem_lat = 3;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step(1, 0, 0, 0, 32'h0);
      if (acc_addr_q.size() > 0 && acc_addr_q[$] == 32'h14) found = 1'b1;
    end
    chk("C_reached_0x14", 32'(found), 32'd1);
    rsp0 = rsp_count;
    nacc = acc_addr_q.size();
    step(1, 0, 0, 1, 32'h103);
    for (int k = 0; k < 20 && acc_addr_q.size() == nacc; k++) step(1, 0, 0, 0, 32'h0);
    chk("C_got_target_req", 32'(acc_addr_q.size() > nacc), 32'd1);
    if (acc_addr_q.size() > nacc) chk("C_target_addr", acc_addr_q[nacc], 32'h100);
    chk("C_stale_drained", 32'(rsp_count - rsp0), 32'd2);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1, 0, 0, 0, 32'h0);
      if (if_id_out.valid) found = 1'b1;
    end
    chk("C_target_valid", 32'(found), 32'd1);
    chk("C_target_pc", if_id_out.pc, 32'h100);

    // Redirect coinciding with a response: nothing to drop afterwards.
    do_reset();
    mem_lat = 1;
    repeat (6) step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 1, 32'h200);
    step(1, 0, 0, 0, 32'h0);
    chk("D_req_valid", 32'(imem_req_valid), 32'd1);
    chk("D_req_addr", imem_req_addr, 32'h200);
    found = 1'b0;
    nsteps = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      step(1, 0, 0, 0, 32'h0);
      nsteps++;
      if (if_id_out.valid) found = 1'b1;
    end
    chk("D_target_pc", if_id_out.pc, 32'h200);
    chk("D_target_latency", 32'(nsteps), 32'd2);

    // Random soak: ready, stall, flush, redirects and memory latency all vary.
    do_reset();
    verbose = 1'b0;
    mem_lat_rand = 1'b1;
    pops = 0;
    max_idle = 0;
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 24) == 0),
           $urandom_range(0, 32'h0000_FFFF));
    end
    chk("E_progress", 32'(pops > 300), 32'd1);
    chk("E_no_starvation", 32'(max_idle < 60), 32'd1);
    $display("random phase retired %0d instructions", pops);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
